// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } fetch_pkt_t;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory req/ack bus; the fetch unit is master, memory is slave.
interface if_fetch_unit_if;

    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/if_wait_timer.sv
// Counts WAIT cycles without ack; sets a sticky error on reaching MAX_WAIT.
module if_wait_timer #(
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic new_req,
    input  logic waiting,
    output logic fetch_err
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (new_req) begin
            cnt_d = '0;
        end else if (waiting && (cnt_q != CW'(MAX_WAIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == CW'(MAX_WAIT)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;

endmodule

// File: rtl/if_fetch_unit.sv
// PC owner and blocking instruction-fetch initiator feeding the IF/ID register.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stalling,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            fetch_pc,
    output logic [31:0]            fetch_inst,
    output logic                   fetch_valid,
    output logic                   fetch_err
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         req_q, req_d;
    logic [31:0]  addr_q, addr_d;
    logic         discard_q, discard_d;
    fetch_pkt_t   hold_q, hold_d;
    fetch_pkt_t   out_q, out_d;
    logic         new_req;
    logic         present;
    logic         waiting;

    assign waiting = (state_q == WAIT) && !imem.ack;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_d     = req_q;
        addr_d    = addr_q;
        discard_d = discard_q;
        hold_d    = hold_q;
        out_d     = out_q;
        new_req   = 1'b0;
        present   = 1'b0;

        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
            unique case (state_q)
                IDLE: ;
                WAIT: begin
                    if (imem.ack) begin
                        addr_d    = align_pc(redirect_pc);
                        discard_d = 1'b0;
                        new_req   = 1'b1;
                    end else begin
                        // Response still owed; swallow it when it arrives.
                        discard_d = 1'b1;
                    end
                end
                HOLD: begin
                    hold_d  = '0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = WAIT;
                    new_req = 1'b1;
                end
                WAIT: begin
                    if (imem.ack) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            addr_d    = pc_q;
                            new_req   = 1'b1;
                        end else if (stalling) begin
                            hold_d  = '{pc: pc_q, inst: imem.rdata, valid: 1'b1};
                            req_d   = 1'b0;
                            state_d = HOLD;
                        end else begin
                            out_d   = '{pc: pc_q, inst: imem.rdata, valid: 1'b1};
                            present = 1'b1;
                            pc_d    = pc_q + PC_STEP;
                            addr_d  = pc_q + PC_STEP;
                            new_req = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!stalling) begin
                        out_d        = hold_q;
                        present      = 1'b1;
                        hold_d.valid = 1'b0;
                        pc_d         = pc_q + PC_STEP;
                        addr_d       = pc_q + PC_STEP;
                        req_d        = 1'b1;
                        state_d      = WAIT;
                        new_req      = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Downstream consumes every unstalled edge, so an empty edge is a bubble.
        if (!stalling && !present) begin
            out_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            req_q     <= 1'b0;
            addr_q    <= '0;
            discard_q <= 1'b0;
            hold_q    <= '0;
            out_q     <= '{pc: '0, inst: NOP_INST, valid: 1'b0};
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
            hold_q    <= hold_d;
            out_q     <= out_d;
        end
    end

    if_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .new_req   (new_req),
        .waiting   (waiting),
        .fetch_err (fetch_err)
    );

    assign imem.req    = req_q;
    assign imem.addr   = addr_q;
    assign fetch_pc    = out_q.pc;
    assign fetch_inst  = out_q.inst;
    assign fetch_valid = out_q.valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed and randomized bench for if_fetch_unit against a transaction-level model.
module tb_if_fetch_unit;

    localparam int          MAXW = 8;
    localparam logic [31:0] KEY  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stalling;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        fetch_valid;
    logic        fetch_err;

    if_fetch_unit_if imem ();

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stalling       (stalling),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem),
        .fetch_pc       (fetch_pc),
        .fetch_inst     (fetch_inst),
        .fetch_valid    (fetch_valid),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Memory responder: 0 = fixed latency, 1 = random ack, 2 = never acks.
    int mem_mode;
    int mem_lat;
    int mem_age;

    // Reference model: pc, one outstanding request, optional held packet, output packet.
    logic [31:0] m_pc, m_req_addr, h_pc, h_inst, o_pc, o_inst;
    bit          m_busy, m_stale, m_held, m_err, o_valid;
    int          m_waits;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_req_addr = 32'h0; m_busy = 0; m_stale = 0; m_held = 0;
        m_err = 0; m_waits = 0; o_pc = 32'h0; o_inst = 32'h0000_0013; o_valid = 0;
    endtask

    task automatic issue(input logic [31:0] a);
        m_req_addr = a; m_busy = 1; m_waits = 0;
    endtask

    task automatic model_edge(input bit st, input bit rv, input logic [31:0] rpc,
                              input bit ack, input logic [31:0] rdata);
        bit got   = m_busy && ack;
        bit shown = 0;
        if (m_busy && !ack && m_waits < MAXW) m_waits++;
        if (rv) begin
            m_pc = rpc & 32'hFFFF_FFFC;
            if (m_held) m_held = 0;
            else if (got) begin m_stale = 0; issue(m_pc); end
            else if (m_busy) m_stale = 1;
        end else if (m_held) begin
            if (!st) begin
                o_pc = h_pc; o_inst = h_inst; o_valid = 1; shown = 1;
                m_held = 0; m_pc = m_pc + 4; issue(m_pc);
            end
        end else if (!m_busy) begin
            issue(m_pc);
        end else if (got) begin
            if (m_stale) begin
                m_stale = 0; issue(m_pc);
            end else if (st) begin
                h_pc = m_pc; h_inst = rdata; m_held = 1; m_busy = 0;
            end else begin
                o_pc = m_pc; o_inst = rdata; o_valid = 1; shown = 1;
                m_pc = m_pc + 4; issue(m_pc);
            end
        end
        if (!st && !shown) o_valid = 0;
        if (m_waits >= MAXW) m_err = 1;
    endtask

    task automatic drive_mem();
        bit a;
        case (mem_mode)
            0:       a = imem.req && (mem_age >= mem_lat);
            1:       a = imem.req && ($urandom_range(0, 2) == 0);
            default: a = 0;
        endcase
        imem.ack   = a;
        imem.rdata = a ? (imem.addr ^ KEY) : $urandom();
    endtask

    task automatic check_all();
        chk("imem_req", 32'(imem.req), 32'(m_busy));
        if (m_busy) chk("imem_addr", imem.addr, m_req_addr);
        chk("fetch_valid", 32'(fetch_valid), 32'(o_valid));
        chk("fetch_pc", fetch_pc, o_pc);
        chk("fetch_inst", fetch_inst, o_inst);
        chk("fetch_err", 32'(fetch_err), 32'(m_err));
    endtask

    // Inputs and memory are set at the negedge; the model consumes them for the next edge.
    task automatic step();
        bit req_pre = imem.req;
        bit ack_pre = imem.ack;
        if (reset) model_reset();
        else model_edge(stalling, redirect_valid, redirect_pc, imem.ack, imem.rdata);
        @(posedge clk);
        @(negedge clk);
        mem_age = (req_pre && !ack_pre) ? mem_age + 1 : 0;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive_mem();
            step();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stalling = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        mem_mode = 0; mem_lat = 0; mem_age = 0;
        imem.ack = 1'b0; imem.rdata = '0;
        model_reset();
        @(negedge clk);

        // Reset state
        run(2);
        chk("rst_addr", imem.addr, 32'h0);
        chk("rst_inst", fetch_inst, 32'h0000_0013);
        reset = 1'b0;

        // Zero-wait memory streams one instruction per cycle
        run(1);
        chk("first_req_addr", imem.addr, 32'h0);
        run(9);

        // Three-cycle ack latency
        mem_lat = 3;
        run(20);

        // Stall on the ack cycle of address 8, held for five cycles
        do_reset();
        mem_lat = 0;
        for (int i = 0; i < 20 && !(m_busy && m_req_addr == 32'h8); i++) run(1);
        chk("stall_at_addr", imem.addr, 32'h8);
        stalling = 1'b1;
        run(5);
        stalling = 1'b0;
        run(1);
        chk("stall_release_pc", fetch_pc, 32'h8);
        chk("stall_next_addr", imem.addr, 32'hC);
        run(5);

        // Redirect while the request to 0x10 is outstanding
        do_reset();
        mem_lat = 3;
        for (int i = 0; i < 60 && !(m_busy && m_req_addr == 32'h10); i++) run(1);
        chk("redir_at_addr", imem.addr, 32'h10);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        run(1);
        redirect_valid = 1'b0;
        run(20);

        // Redirect coincident with ack, unaligned target
        do_reset();
        mem_lat = 1;
        for (int i = 0; i < 40; i++) begin
            drive_mem();
            if (imem.ack && m_req_addr == 32'h8) begin
                redirect_valid = 1'b1; redirect_pc = 32'h203;
                step();
                redirect_valid = 1'b0;
                chk("redir_ack_addr", imem.addr, 32'h200);
                break;
            end
            step();
        end
        run(8);

        // PC wrap past the top of the address space
        mem_lat = 0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        run(1);
        redirect_valid = 1'b0;
        run(8);

        // Randomized stall / redirect / ack traffic
        mem_mode = 1;
        for (int i = 0; i < 400; i++) begin
            stalling       = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom();
            run(1);
        end
        stalling = 1'b0; redirect_valid = 1'b0;

        // Memory never acks: timeout error, then reset recovery
        mem_mode = 2;
        do_reset();
        run(12);
        chk("err_sticky", 32'(fetch_err), 32'h1);
        do_reset();
        chk("err_cleared", 32'(fetch_err), 32'h0);
        mem_mode = 0; mem_lat = 0;
        run(1);
        chk("restart_addr", imem.addr, 32'h0);
        run(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
